// File: rtl/count_display_ctrl.sv
// Loadable up/down 0..15 counter with BCD split and a
// blanked two-digit time-shared seven-segment scan.
module count_display_ctrl #(
  parameter int PRESCALE = 4,
  parameter int TICK_DIV = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       En,
  input  logic       Up,
  input  logic       Load,
  input  logic [3:0] LoadVal,
  output logic [3:0] Count,
  output logic [3:0] Tens,
  output logic [3:0] Ones,
  output logic [3:0] SegDigit,
  output logic [1:0] DigitSel,
  output logic       Blank
);

  localparam int PW = $clog2(PRESCALE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ONES  = 2'd0,
    GAP_A = 2'd1,
    TENS  = 2'd2,
    GAP_B = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [TW-1:0] step_cnt;
  logic [PW-1:0] pre_cnt;
  logic          step_done;
  logic          scan_tick;
  logic          over_nine;

  assign step_done = (step_cnt == TICK_LAST);
  assign scan_tick = (pre_cnt == PRE_LAST);

  // Step-rate divider; a load restarts the interval.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      step_cnt <= '0;
    end else if (Load) begin
      step_cnt <= '0;
    end else if (En) begin
      if (step_done) begin
        step_cnt <= '0;
      end else begin
        step_cnt <= step_cnt + TW'(1);
      end
    end
  end

  // Count register: load beats stepping; wraps naturally in 4 bits.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Count <= 4'd0;
    end else if (Load) begin
      Count <= LoadVal;
    end else if (En && step_done) begin
      if (Up) begin
        Count <= Count + 4'd1;
      end else begin
        Count <= Count - 4'd1;
      end
    end
  end

  // Free-running scan prescaler.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pre_cnt <= '0;
    end else if (scan_tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // Scan state register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= ONES;
    end else begin
      state <= state_nxt;
    end
  end

  // Next scan state: one slot per scan tick.
  always_comb begin
    state_nxt = state;
    if (scan_tick) begin
      unique case (state)
        ONES:    state_nxt = GAP_A;
        GAP_A:   state_nxt = TENS;
        TENS:    state_nxt = GAP_B;
        GAP_B:   state_nxt = ONES;
        default: state_nxt = ONES;
      endcase
    end
  end

  // BCD split straight off the count register.
  always_comb begin
    over_nine = (Count >= 4'd10);
    Tens = {3'b000, over_nine};
    Ones = over_nine ? (Count - 4'd10) : Count;
  end

  // Moore display decode; gaps and a zero tens digit stay dark.
  always_comb begin
    DigitSel = 2'b11;
    SegDigit = 4'd0;
    Blank    = 1'b1;
    unique case (state)
      ONES: begin
        DigitSel = 2'b10;
        SegDigit = Ones;
        Blank    = 1'b0;
      end
      TENS: begin
        if (Tens != 4'd0) begin
          DigitSel = 2'b01;
          SegDigit = Tens;
          Blank    = 1'b0;
        end
      end
      default: begin
        DigitSel = 2'b11;
        SegDigit = 4'd0;
        Blank    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_count_display_ctrl.sv
// Directed bench for count_display_ctrl with a cycle model
// feeding a scoreboard queue of expected outputs.
module tb_count_display_ctrl;

  logic       Clk;
  logic       Rst;
  logic       En;
  logic       Up;
  logic       Load;
  logic [3:0] LoadVal;
  logic [3:0] Count;
  logic [3:0] Tens;
  logic [3:0] Ones;
  logic [3:0] SegDigit;
  logic [1:0] DigitSel;
  logic       Blank;

  count_display_ctrl #(.PRESCALE(4), .TICK_DIV(3)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Up(Up),
    .Load(Load), .LoadVal(LoadVal),
    .Count(Count), .Tens(Tens), .Ones(Ones),
    .SegDigit(SegDigit), .DigitSel(DigitSel),
    .Blank(Blank)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0] c;
    logic [3:0] t;
    logic [3:0] o;
    logic [3:0] s;
    logic [1:0] d;
    logic       b;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  int m_count = 0;
  int m_step = 0;
  int m_pre = 0;
  int m_slot = 0;

  task automatic chk(input string tag,
                     input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance model one clock and produce expected outputs.
  function automatic exp_t model(input logic rst, input logic en,
                                 input logic up, input logic ld,
                                 input logic [3:0] lv);
    exp_t e;
    bit tick;
    if (rst) begin
      m_count = 0; m_step = 0; m_pre = 0; m_slot = 0;
    end else begin
      tick = (m_pre == 3);
      m_pre = tick ? 0 : m_pre + 1;
      if (tick) m_slot = (m_slot + 1) % 4;
      if (ld) begin
        m_count = lv; m_step = 0;
      end else if (en) begin
        if (m_step == 2) begin
          m_step = 0;
          m_count = up ? (m_count + 1) % 16 : (m_count + 15) % 16;
        end else begin
          m_step++;
        end
      end
    end
    e.c = 4'(m_count);
    e.t = 4'(m_count / 10);
    e.o = 4'(m_count % 10);
    e.s = 4'd0; e.d = 2'b11; e.b = 1'b1;
    if (m_slot == 0) begin
      e.s = e.o; e.d = 2'b10; e.b = 1'b0;
    end else if (m_slot == 2 && m_count >= 10) begin
      e.s = 4'd1; e.d = 2'b01; e.b = 1'b0;
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic en,
                      input logic up, input logic ld,
                      input logic [3:0] lv);
    exp_t e;
    @(negedge Clk);
    Rst = rst; En = en; Up = up; Load = ld; LoadVal = lv;
    q.push_back(model(rst, en, up, ld, lv));
    @(posedge Clk);
    #1;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL sb_empty observed=0 expected=1");
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("count", Count, e.c);
      chk("tens", Tens, e.t);
      chk("ones", Ones, e.o);
      chk("seg", SegDigit, e.s);
      chk("dsel", {2'b00, DigitSel}, {2'b00, e.d});
      chk("blank", {3'b000, Blank}, {3'b000, e.b});
      chk("dsel_nz", {3'b000, DigitSel == 2'b00}, 4'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic run(input int n, input logic up);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, up, 1'b0, 4'd0);
  endtask

  initial begin
    Rst = 1'b1; En = 1'b0; Up = 1'b1; Load = 1'b0; LoadVal = 4'd0;

    // 1: reset then free scan with a blanked tens digit
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("rst_count", Count, 4'd0);
    chk("rst_dsel", {2'b00, DigitSel}, 4'b0010);
    chk("rst_blank", {3'b000, Blank}, 4'd0);
    idle(4);
    chk("gap_a_dsel", {2'b00, DigitSel}, 4'b0011);
    idle(4);
    chk("tens0_blank", {3'b000, Blank}, 4'd1);
    idle(24);

    // 2: load 13 and watch both digits
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd13);
    chk("ld13_count", Count, 4'd13);
    chk("ld13_tens", Tens, 4'd1);
    chk("ld13_ones", Ones, 4'd3);
    idle(16);

    // 3: count up through the wrap
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd14);
    run(3, 1'b1);
    chk("up_15", Count, 4'd15);
    chk("up_15_tens", Tens, 4'd1);
    run(3, 1'b1);
    chk("wrap_0", Count, 4'd0);
    chk("wrap_0_tens", Tens, 4'd0);

    // 4: count down through the wrap, then pause
    step(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    run(3, 1'b0);
    chk("down_15", Count, 4'd15);
    run(1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    chk("hold_15", Count, 4'd15);
    run(1, 1'b0);
    chk("resume_15", Count, 4'd15);
    run(1, 1'b0);
    chk("resume_14", Count, 4'd14);

    // 5: load collides with a step terminal
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
    run(2, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 4'd7);
    chk("ld_wins", Count, 4'd7);
    run(2, 1'b1);
    chk("post_ld_7", Count, 4'd7);
    run(1, 1'b1);
    chk("post_ld_8", Count, 4'd8);

    // 6: reset in the middle of the tens slot
    step(1'b0, 1'b0, 1'b1, 1'b1, 4'd12);
    for (int i = 0; i < 32; i++) begin
      if (!(m_slot == 2 && m_pre == 1)) idle(1);
    end
    chk("tens_dsel", {2'b00, DigitSel}, 4'b0001);
    chk("tens_seg", SegDigit, 4'd1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    chk("mid_rst_count", Count, 4'd0);
    chk("mid_rst_dsel", {2'b00, DigitSel}, 4'b0010);
    idle(3);
    chk("ones_slot_end", {2'b00, DigitSel}, 4'b0010);
    idle(1);
    chk("gap_after_rst", {2'b00, DigitSel}, 4'b0011);
    idle(12);
    chk("cycle_restart", {2'b00, DigitSel}, 4'b0010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
